// File: rtl/elevator_scheduler.sv
// Collective (SCAN) scheduler for a 4-floor car: latches hall and car calls,
// tracks the car floor from level-sensor pulses, sequences motor and door.
module elevator_scheduler #(
  parameter int NFLOOR = 4,
  parameter int FW     = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NFLOOR-2:0] up_req,
  input  logic [NFLOOR-2:0] dn_req,
  input  logic [NFLOOR-1:0] car_req,
  input  logic              floor_tick,
  input  logic              door_done,
  output logic [FW-1:0]     cur_floor,
  output logic              motor_en,
  output logic              dir_up,
  output logic              door_open,
  output logic [NFLOOR-2:0] up_pend,
  output logic [NFLOOR-2:0] dn_pend,
  output logic [NFLOOR-1:0] car_pend
);

  typedef enum logic [1:0] {IDLE, MOVE_UP, MOVE_DOWN, STOP} state_t;

  localparam logic [FW-1:0] TOP = FW'(NFLOOR - 1);

  state_t            state_q, state_d;
  logic [FW-1:0]     cur_floor_q, cur_floor_d;
  logic              last_up_q, last_up_d;
  logic [NFLOOR-2:0] up_pend_q, up_pend_d, dn_pend_q, dn_pend_d;
  logic [NFLOOR-1:0] car_pend_q, car_pend_d;
  logic              motor_en_q, dir_up_q, door_open_q;

  // Floor-aligned views of the calls, including requests arriving this cycle
  logic [NFLOOR-1:0] up_all, dn_all, car_all, any_all;
  logic [FW-1:0]     nxt_up_f, nxt_dn_f;
  logic              serve, above_here, below_here;

  assign up_all   = {1'b0, up_pend_q | up_req};
  assign dn_all   = {dn_pend_q | dn_req, 1'b0};
  assign car_all  = car_pend_q | car_req;
  assign any_all  = up_all | dn_all | car_all;
  assign nxt_up_f = (cur_floor_q == TOP) ? TOP : cur_floor_q + 1'b1;
  assign nxt_dn_f = (cur_floor_q == '0) ? '0 : cur_floor_q - 1'b1;

  function automatic logic above_of(input logic [NFLOOR-1:0] v, input logic [FW-1:0] f);
    logic [NFLOOR-1:0] ones;
    ones = '1;
    return |(v & ((ones << f) << 1));
  endfunction

  function automatic logic below_of(input logic [NFLOOR-1:0] v, input logic [FW-1:0] f);
    logic [NFLOOR-1:0] ones;
    ones = '1;
    return |(v & ~(ones << f));
  endfunction

  always_comb begin
    state_d     = state_q;
    cur_floor_d = cur_floor_q;
    last_up_d   = last_up_q;
    case (state_q)
      IDLE: begin
        if (car_all[cur_floor_q] | up_all[cur_floor_q] | dn_all[cur_floor_q]) begin
          state_d = STOP;
        end else if (above_of(any_all, cur_floor_q)) begin
          state_d   = MOVE_UP;
          last_up_d = 1'b1;
        end else if (below_of(any_all, cur_floor_q)) begin
          state_d   = MOVE_DOWN;
          last_up_d = 1'b0;
        end
      end
      MOVE_UP: begin
        if (floor_tick) begin
          cur_floor_d = nxt_up_f;
          if (car_all[nxt_up_f] | up_all[nxt_up_f] | (nxt_up_f == TOP) |
              (dn_all[nxt_up_f] & ~above_of(any_all, nxt_up_f))) begin
            state_d = STOP;
          end
        end
      end
      MOVE_DOWN: begin
        if (floor_tick) begin
          cur_floor_d = nxt_dn_f;
          if (car_all[nxt_dn_f] | dn_all[nxt_dn_f] | (nxt_dn_f == '0) |
              (up_all[nxt_dn_f] & ~below_of(any_all, nxt_dn_f))) begin
            state_d = STOP;
          end
        end
      end
      STOP: begin
        // Keep sweeping in the last direction while calls remain that way
        if (door_done) begin
          if (last_up_q && above_of(any_all, cur_floor_q)) begin
            state_d = MOVE_UP;
          end else if (!last_up_q && below_of(any_all, cur_floor_q)) begin
            state_d = MOVE_DOWN;
          end else if (above_of(any_all, cur_floor_q)) begin
            state_d   = MOVE_UP;
            last_up_d = 1'b1;
          end else if (below_of(any_all, cur_floor_q)) begin
            state_d   = MOVE_DOWN;
            last_up_d = 1'b0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Service clears are applied on the edge entering STOP and every STOP cycle
  assign serve      = (state_d == STOP);
  assign above_here = above_of(any_all, cur_floor_d);
  assign below_here = below_of(any_all, cur_floor_d);

  always_comb begin
    for (int i = 0; i < NFLOOR - 1; i++) begin
      up_pend_d[i] = up_all[i] & ~(serve && (cur_floor_d == FW'(i)) && (last_up_d || !below_here));
      dn_pend_d[i] = dn_all[i+1] & ~(serve && (cur_floor_d == FW'(i + 1)) && (!last_up_d || !above_here));
    end
    for (int i = 0; i < NFLOOR; i++) begin
      car_pend_d[i] = car_all[i] & ~(serve && (cur_floor_d == FW'(i)));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cur_floor_q <= '0;
      last_up_q   <= 1'b1;
      up_pend_q   <= '0;
      dn_pend_q   <= '0;
      car_pend_q  <= '0;
      motor_en_q  <= 1'b0;
      dir_up_q    <= 1'b0;
      door_open_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cur_floor_q <= cur_floor_d;
      last_up_q   <= last_up_d;
      up_pend_q   <= up_pend_d;
      dn_pend_q   <= dn_pend_d;
      car_pend_q  <= car_pend_d;
      motor_en_q  <= (state_d == MOVE_UP) || (state_d == MOVE_DOWN);
      dir_up_q    <= (state_d == MOVE_UP);
      door_open_q <= (state_d == STOP) && (state_q != STOP);
    end
  end

  assign cur_floor = cur_floor_q;
  assign motor_en  = motor_en_q;
  assign dir_up    = dir_up_q;
  assign door_open = door_open_q;
  assign up_pend   = up_pend_q;
  assign dn_pend   = dn_pend_q;
  assign car_pend  = car_pend_q;

endmodule
